// File: rtl/ble_tx_fifo_read_ctrl_pkg.sv
// BLE TX FIFO read controller: shared types and defaults.
// FSM state encoding plus default word and size widths.
package ble_tx_fifo_read_ctrl_pkg;

  localparam int DEF_WORD_W = 32;
  localparam int DEF_SIZE_W = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ble_tx_fifo_read_ctrl_if.sv
// FIFO read port between the TX FIFO read-pointer logic and the read controller.
// master: fifo_rd_inc out, fifo_empty/fifo_rdata in. slave: the FIFO side.
interface ble_tx_fifo_read_ctrl_if
  import ble_tx_fifo_read_ctrl_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
);

  logic              fifo_rd_inc;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_rdata;

  modport master (
    output fifo_rd_inc,
    input  fifo_empty,
    input  fifo_rdata
  );

  modport slave (
    input  fifo_rd_inc,
    output fifo_empty,
    output fifo_rdata
  );

endinterface

// File: rtl/ble_tx_fifo_read_ctrl_serializer.sv
// Word shift register with in-word bit counter, LSB-first.
// Ports: clk, rst_n, load/din, shift, bit_out (shreg[0]), last_bit (bit WORD_W-1 of word).
module ble_tx_bit_serializer
  import ble_tx_fifo_read_ctrl_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic              bit_out,
  output logic              last_bit
);

  localparam int CW = $clog2(WORD_W);

  logic [WORD_W-1:0] shreg;
  logic [CW-1:0]     word_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      word_bit <= '0;
    end else if (load) begin
      shreg    <= din;
      word_bit <= '0;
    end else if (shift) begin
      shreg    <= shreg >> 1;
      word_bit <= word_bit + 1'b1;
    end
  end

  assign bit_out  = shreg[0];
  assign last_bit = (word_bit == CW'(WORD_W - 1));

endmodule

// File: rtl/ble_tx_fifo_read_ctrl.sv
// BLE PHY TX FIFO read sequencer: pops words, serializes them at sym_tick rate.
// Ports: CLK, rst_n, tx_start/tx_abort/data_size, sym_tick, status_clr,
//   fifo (read port master), tx_bit/tx_bit_vld, tx_busy, tx_irq, underrun.
module ble_tx_fifo_read_ctrl
  import ble_tx_fifo_read_ctrl_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int SIZE_W = DEF_SIZE_W
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic                    tx_start,
  input  logic                    tx_abort,
  input  logic [SIZE_W-1:0]       data_size,
  input  logic                    sym_tick,
  input  logic                    status_clr,
  ble_tx_fifo_read_ctrl_if.master fifo,
  output logic                    tx_bit,
  output logic                    tx_bit_vld,
  output logic                    tx_busy,
  output logic                    tx_irq,
  output logic                    underrun
);

  state_t            state;
  logic [SIZE_W-1:0] size_q;
  logic [SIZE_W-1:0] bit_cnt;
  logic [SIZE_W-1:0] cnt_nxt;
  logic              load;
  logic              shift;
  logic              bit_out;
  logic              last_bit;
  logic              first_word;

  // No bit sent yet means the word being fetched is the packet's first.
  assign first_word = (bit_cnt == '0);
  assign cnt_nxt    = bit_cnt + 1'b1;

  // Abort suppresses the pop and the shift in its own cycle.
  assign load  = (state == FETCH) && !fifo.fifo_empty && !tx_abort;
  assign shift = (state == SHIFT) && sym_tick && !tx_abort;

  assign fifo.fifo_rd_inc = load;
  assign tx_busy          = (state != IDLE);

  ble_tx_bit_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .clk      (CLK),
    .rst_n    (rst_n),
    .load     (load),
    .shift    (shift),
    .din      (fifo.fifo_rdata),
    .bit_out  (bit_out),
    .last_bit (last_bit)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      size_q     <= '0;
      bit_cnt    <= '0;
      tx_bit     <= 1'b0;
      tx_bit_vld <= 1'b0;
      tx_irq     <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      tx_bit_vld <= 1'b0;
      tx_irq     <= 1'b0;
      // A set later in this block overrides the clear.
      if (status_clr) underrun <= 1'b0;
      if (tx_abort) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (tx_start) begin
              if (data_size == '0) begin
                tx_irq <= 1'b1;
              end else begin
                size_q  <= data_size;
                bit_cnt <= '0;
                state   <= FETCH;
              end
            end
          end
          FETCH: begin
            if (load) begin
              state <= SHIFT;
            end else if (sym_tick && !first_word) begin
              underrun <= 1'b1;
              state    <= DONE;
            end
          end
          SHIFT: begin
            if (shift) begin
              tx_bit     <= bit_out;
              tx_bit_vld <= 1'b1;
              bit_cnt    <= cnt_nxt;
              if (cnt_nxt == size_q) begin
                state <= DONE;
              end else if (last_bit) begin
                state <= FETCH;
              end
            end
          end
          DONE: begin
            tx_irq <= 1'b1;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
